// File: rtl/alu_byte_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_byte_ctrl_pkg
// Brief  : Shared types and constants for the ALU byte-stream front-end:
//          FSM state encoding, ALU unit-select codes, STATUS bit layout and
//          the reserved-opcode mask.
// Rev    : 1.0  initial release
// ============================================================================
package alu_byte_ctrl_pkg;

  // Controller FSM states, in frame order
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RX_A = 3'd1,
    ST_RX_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WAIT = 3'd4,
    ST_CAPT = 3'd5,
    ST_TX   = 3'd6
  } state_e;

  // ALU unit selected by function code bits [3:2]
  localparam logic [1:0] c_unit_arith = 2'b00;
  localparam logic [1:0] c_unit_logic = 2'b01;
  localparam logic [1:0] c_unit_cmp   = 2'b10;
  localparam logic [1:0] c_unit_shift = 2'b11;

  // STATUS byte = {bad, 3'b0, opc[3:0]}
  localparam int c_status_bad_bit = 7;

  // Opcode bits that must be zero for a good frame
  localparam logic [7:0] c_opc_rsvd_mask = 8'hF0;

endpackage : alu_byte_ctrl_pkg
`default_nettype wire

// File: rtl/alu_byte_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : alu_byte_ctrl_if
// Brief  : Bundles the RX/TX byte streams and the ALU operand/result ports of
//          the byte front-end. master = controller view, slave = environment
//          (byte source/sink and ALU) view.
// Rev    : 1.0  initial release
// ============================================================================
interface alu_byte_ctrl_if #(
  parameter int WIDTH = 16
) ();

  // Command byte stream (into the controller)
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;

  // Response byte stream (out of the controller)
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;

  // ALU operands / function code
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [3:0]         alu_fun;

  // ALU unit results and unit-valid flags
  logic [2*WIDTH-1:0] arith_out;
  logic [WIDTH-1:0]   logic_out;
  logic [WIDTH-1:0]   cmp_out;
  logic [WIDTH-1:0]   shift_out;
  logic               arith_flag;
  logic               logic_flag;
  logic               cmp_flag;
  logic               shift_flag;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready,
    output tx_data, tx_valid,
    input  tx_ready,
    output alu_a, alu_b, alu_fun,
    input  arith_out, logic_out, cmp_out, shift_out,
    input  arith_flag, logic_flag, cmp_flag, shift_flag
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready,
    input  tx_data, tx_valid,
    output tx_ready,
    input  alu_a, alu_b, alu_fun,
    output arith_out, logic_out, cmp_out, shift_out,
    output arith_flag, logic_flag, cmp_flag, shift_flag
  );

endinterface : alu_byte_ctrl_if
`default_nettype wire

// File: rtl/alu_byte_ctrl_ser.sv
`default_nettype none
// ============================================================================
// Module : alu_byte_ser
// Brief  : Loads a multi-byte word and emits it MSB-first on a valid/ready
//          byte stream. done is high during the handshake of the last byte.
// Rev    : 1.0  initial release
// ============================================================================
module alu_byte_ser #(
  parameter int NBYTES = 5
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  load,
  input  wire logic [8*NBYTES-1:0]   din,
  output logic      [7:0]            tx_data,
  output logic                       tx_valid,
  input  wire logic                  tx_ready,
  output logic                       done
);

  localparam int SW = $clog2(NBYTES + 1);
  localparam logic [SW-1:0] c_last = SW'(NBYTES - 1);

  logic [8*NBYTES-1:0] sh_q, sh_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                w_fire;

  assign w_fire   = valid_q & tx_ready;
  assign tx_data  = sh_q[8*NBYTES-1 -: 8];
  assign tx_valid = valid_q;
  assign done     = w_fire & (cnt_q == c_last);

  // Next-state: load a new word, or shift one byte out per handshake
  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load) begin
      sh_d    = din;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (w_fire) begin
      sh_d = sh_q << 8;
      if (cnt_q == c_last) begin
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Serializer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule : alu_byte_ser
`default_nettype wire

// File: rtl/alu_byte_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_byte_ctrl
// Brief  : Byte-framed command front-end for the ALU. Receives OPC, A, B on
//          the RX stream, drives the ALU, captures the enabled unit's output
//          and returns {STATUS, RESULT} on the TX stream.
// Rev    : 1.0  initial release
// ============================================================================
module alu_byte_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  alu_byte_ctrl_if.master  bus,
  output logic             busy,
  output logic             err
);

  import alu_byte_ctrl_pkg::*;

  localparam int N  = WIDTH / 8;
  localparam int NB = 2 * N + 1;
  localparam int CW = $clog2(2 * N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_last_byte = CW'(N - 1);
  localparam logic [TW-1:0] c_tmo_last  = TW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [3:0]           opc_q, opc_d;
  logic                 bad_q, bad_d;
  // Holds all operand bytes except the one arriving on the current edge
  logic [2*WIDTH-9:0]   op_sh_q, op_sh_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [3:0]           alu_fun_q, alu_fun_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 w_accept;
  logic [2*WIDTH-1:0]   w_ops;
  logic                 w_last;
  logic                 w_tmo_hit;
  logic [2*WIDTH-1:0]   w_unit_res;
  logic                 w_unit_flag;
  logic                 w_cap_bad;
  logic [7:0]           w_status;
  logic [2*WIDTH-1:0]   w_result;
  logic                 w_ser_load;
  logic                 w_ser_done;

  assign w_accept  = bus.rx_valid & rx_ready_q;
  assign w_ops     = {op_sh_q, bus.rx_data};
  assign w_last    = (cnt_q == c_last_byte);
  assign w_tmo_hit = (tmo_q == c_tmo_last);

  // Select the enabled unit's result; a missing flag or a bad frame yields zero
  always_comb begin
    w_unit_res  = '0;
    w_unit_flag = 1'b0;
    case (bus.alu_fun[3:2])
      c_unit_arith: begin
        w_unit_res  = bus.arith_out;
        w_unit_flag = bus.arith_flag;
      end
      c_unit_logic: begin
        w_unit_res  = {{WIDTH{1'b0}}, bus.logic_out};
        w_unit_flag = bus.logic_flag;
      end
      c_unit_cmp: begin
        w_unit_res  = {{WIDTH{1'b0}}, bus.cmp_out};
        w_unit_flag = bus.cmp_flag;
      end
      default: begin
        w_unit_res  = {{WIDTH{1'b0}}, bus.shift_out};
        w_unit_flag = bus.shift_flag;
      end
    endcase
    w_cap_bad = bad_q | ~w_unit_flag;
    w_result  = w_cap_bad ? '0 : w_unit_res;
    w_status  = {4'b0000, opc_q};
    w_status[c_status_bad_bit] = w_cap_bad;
  end

  assign w_ser_load = (state_q == ST_CAPT);

  alu_byte_ser #(
    .NBYTES (NB)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_ser_load),
    .din      ({w_status, w_result}),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .tx_ready (bus.tx_ready),
    .done     (w_ser_done)
  );

  // Frame FSM next-state: receive, execute, capture, transmit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    opc_d     = opc_q;
    bad_d     = bad_q;
    op_sh_d   = op_sh_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_fun_d = alu_fun_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          opc_d   = bus.rx_data[3:0];
          bad_d   = |(bus.rx_data & c_opc_rsvd_mask);
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = ST_RX_A;
        end
      end
      ST_RX_A, ST_RX_B: begin
        if (w_accept) begin
          op_sh_d = w_ops[2*WIDTH-9:0];
          tmo_d   = '0;
          if (w_last) begin
            cnt_d = '0;
            if (state_q == ST_RX_A) begin
              state_d = ST_RX_B;
            end else if (bad_q) begin
              // Bad frame: skip the ALU, leave its inputs untouched
              state_d = ST_CAPT;
            end else begin
              alu_a_d   = w_ops[2*WIDTH-1:WIDTH];
              alu_b_d   = w_ops[WIDTH-1:0];
              alu_fun_d = opc_q;
              state_d   = ST_EXEC;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (w_tmo_hit) begin
          // Source went quiet mid-frame: drop it silently apart from ERR
          tmo_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_EXEC: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_TX;
      ST_TX: begin
        if (w_ser_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_RX_A) || (state_d == ST_RX_B);
    busy_d     = (state_d != ST_IDLE);
  end

  // Controller registers, including the registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      opc_q      <= '0;
      bad_q      <= 1'b0;
      op_sh_q    <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_fun_q  <= '0;
      rx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      opc_q      <= opc_d;
      bad_q      <= bad_d;
      op_sh_q    <= op_sh_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_fun_q  <= alu_fun_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_fun  = alu_fun_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule : alu_byte_ctrl
`default_nettype wire

// File: tb/tb_alu_byte_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_byte_ctrl
// Brief  : Directed self-checking bench for alu_byte_ctrl (WIDTH=16,
//          TIMEOUT=8), with the ALU modelled by fixed per-test result values.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_byte_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic err;

  int checks   = 0;
  int failures = 0;

  alu_byte_ctrl_if #(.WIDTH(16)) bus ();

  alu_byte_ctrl #(
    .WIDTH   (16),
    .TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the controller accepts it
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) chk("rx_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
  endtask

  // Take one response byte with tx_ready held high
  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n;
    @(negedge clk);
    bus.tx_ready = 1'b1;
    n = 0;
    while (!bus.tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_valid) chk({tag, "_valid_timeout"}, 64'd0, 64'd1);
    else chk(tag, 64'(bus.tx_data), 64'(exp));
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b0;
  endtask

  task automatic recv5(input string tag, input logic [7:0] e0, e1, e2, e3, e4);
    recv_byte({tag, "_b0"}, e0);
    recv_byte({tag, "_b1"}, e1);
    recv_byte({tag, "_b2"}, e2);
    recv_byte({tag, "_b3"}, e3);
    recv_byte({tag, "_b4"}, e4);
  endtask

  initial begin : main
    logic [7:0] got [5];
    logic [7:0] held;
    logic [3:0] pat;
    bit         stalled;
    int         n_got;
    int         pulses;
    int         tx_seen;

    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.tx_ready   = 1'b0;
    bus.arith_out  = 32'h0;
    bus.logic_out  = 16'h0;
    bus.cmp_out    = 16'h0;
    bus.shift_out  = 16'h0;
    bus.arith_flag = 1'b0;
    bus.logic_flag = 1'b0;
    bus.cmp_flag   = 1'b0;
    bus.shift_flag = 1'b0;

    // Reset state
    #23;
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
    chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1 Add, with response latency
    bus.arith_out  = 32'h0000_0008;
    bus.arith_flag = 1'b1;
    send5(8'h00, 8'h00, 8'h05, 8'h00, 8'h03);
    chk("add_alu_fun", 64'(bus.alu_fun), 64'h0);
    chk("add_alu_a", 64'(bus.alu_a), 64'h0005);
    chk("add_alu_b", 64'(bus.alu_b), 64'h0003);
    chk("add_busy", 64'(busy), 64'd1);
    chk("add_rx_ready_exec", 64'(bus.rx_ready), 64'd0);
    @(posedge clk); #1;
    chk("lat_t1_valid", 64'(bus.tx_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_t2_valid", 64'(bus.tx_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_t3_valid", 64'(bus.tx_valid), 64'd1);
    recv5("add", 8'h00, 8'h00, 8'h00, 8'h00, 8'h08);
    @(posedge clk); #1;
    chk("add_done_busy", 64'(busy), 64'd0);

    // 2 Multiply
    bus.arith_out = 32'h0001_0000;
    send5(8'h02, 8'h01, 8'h00, 8'h01, 8'h00);
    chk("mul_alu_a", 64'(bus.alu_a), 64'h0100);
    recv5("mul", 8'h02, 8'h00, 8'h01, 8'h00, 8'h00);

    // 3 Logic, zero-extended
    bus.logic_out  = 16'h00F0;
    bus.logic_flag = 1'b1;
    send5(8'h04, 8'hF0, 8'hF0, 8'h0F, 8'hF0);
    chk("log_alu_a", 64'(bus.alu_a), 64'hF0F0);
    chk("log_alu_b", 64'(bus.alu_b), 64'h0FF0);
    chk("log_alu_fun", 64'(bus.alu_fun), 64'h4);
    recv5("log", 8'h04, 8'h00, 8'h00, 8'h00, 8'hF0);

    // 4 Bad opcode leaves ALU inputs alone
    send5(8'h30, 8'h11, 8'h22, 8'h33, 8'h44);
    chk("bad_alu_a", 64'(bus.alu_a), 64'hF0F0);
    chk("bad_alu_b", 64'(bus.alu_b), 64'h0FF0);
    chk("bad_alu_fun", 64'(bus.alu_fun), 64'h4);
    recv5("bad", 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);

    // 4b Good compare opcode but compare unit flag low
    bus.cmp_out  = 16'h1234;
    bus.cmp_flag = 1'b0;
    send5(8'h08, 8'h00, 8'h01, 8'h00, 8'h02);
    recv5("noflag", 8'h88, 8'h00, 8'h00, 8'h00, 8'h00);

    // 4c Shift unit, good flag
    bus.shift_out  = 16'hABCD;
    bus.shift_flag = 1'b1;
    send5(8'h0C, 8'h00, 8'h01, 8'h00, 8'h02);
    recv5("shift", 8'h0C, 8'h00, 8'h00, 8'hAB, 8'hCD);

    // 5 Timeout mid-frame
    send_byte(8'h00);
    send_byte(8'h12);
    pulses  = 0;
    tx_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (err) pulses++;
      if (bus.tx_valid) tx_seen++;
    end
    chk("tmo_err_pulses", 64'(pulses), 64'd1);
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_rx_ready", 64'(bus.rx_ready), 64'd1);
    chk("tmo_no_tx", 64'(tx_seen), 64'd0);
    bus.arith_out = 32'h0000_0008;
    send5(8'h00, 8'h00, 8'h05, 8'h00, 8'h03);
    recv5("tmo_add", 8'h00, 8'h00, 8'h00, 8'h00, 8'h08);

    // 6 Backpressure: tx_ready pattern 1,0,0,1 per cycle
    bus.arith_out = 32'h1234_5678;
    send5(8'h01, 8'h00, 8'h01, 8'h00, 8'h02);
    pat     = 4'b1001;
    n_got   = 0;
    stalled = 1'b0;
    held    = 8'h00;
    for (int k = 0; k < 80 && n_got < 5; k++) begin
      @(negedge clk);
      bus.tx_ready = pat[k % 4];
      if (bus.tx_valid) begin
        if (stalled) chk("bp_stable", 64'(bus.tx_data), 64'(held));
        if (bus.tx_ready) begin
          got[n_got] = bus.tx_data;
          n_got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = bus.tx_data;
        end
      end
    end
    @(negedge clk);
    bus.tx_ready = 1'b0;
    chk("bp_count", 64'(n_got), 64'd5);
    if (n_got == 5) begin
      chk("bp_b0", 64'(got[0]), 64'h01);
      chk("bp_b1", 64'(got[1]), 64'h12);
      chk("bp_b2", 64'(got[2]), 64'h34);
      chk("bp_b3", 64'(got[3]), 64'h56);
      chk("bp_b4", 64'(got[4]), 64'h78);
    end

    // Reset in the middle of a response
    bus.arith_out = 32'h0000_0008;
    send5(8'h00, 8'h00, 8'h05, 8'h00, 8'h03);
    recv_byte("mrst_b0", 8'h00);
    recv_byte("mrst_b1", 8'h00);
    rst_n = 1'b0;
    #1;
    chk("mrst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_rx_ready", 64'(bus.rx_ready), 64'd1);
    chk("mrst_alu_a", 64'(bus.alu_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send5(8'h00, 8'h00, 8'h05, 8'h00, 8'h03);
    recv5("post_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends
  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_byte_ctrl
`default_nettype wire
